sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
Shares one single-port synchronous SRAM (1-cycle read latency) between the fetch-stage instruction port and the memory-stage data port. Uses an addr_ok/data_ok handshake per requester and grants at most one access per cycle. It tracks the owner of the in-flight access so the next-cycle response goes to the right requester. Data has priority by default, with a starvation counter that guarantees fetch progress.

Parameters:
STARVE_MAX, 4, consecutive cycles the instruction port may be refused while requesting before it is forced a grant; 0 means pure data priority with no forcing.
AW, 32, address width.

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  synchronous active-low reset
inst_req  in  1  instruction read request
inst_addr  in  AW  instruction address
inst_addr_ok  out  1  instruction request accepted this cycle
inst_data_ok  out  1  instruction read data valid this cycle
inst_rdata  out  32  instruction read data
data_req  in  1  data access request
data_wr  in  1  1 = write, 0 = read
data_wstrb  in  4  byte write strobes, used only when data_wr=1
data_addr  in  AW  data address
data_wdata  in  32  write data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  data read data valid / write complete this cycle
data_rdata  out  32  data read data
sram_en  out  1  SRAM access enable
sram_wen  out  4  SRAM byte write enables
sram_addr  out  AW  SRAM address
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data, valid the cycle after sram_en

Behaviour:
- Reset: when resetn=0 at a clock edge, the owner register becomes NONE and the starvation counter becomes 0. While resetn=0, every output is forced to 0 combinationally.
- Grant (combinational, same cycle):
  - Only inst_req: grant inst.
  - Only data_req: grant data.
  - Both requesting: grant data, unless starve_cnt==STARVE_MAX and STARVE_MAX!=0, in which case grant inst.
  - Neither: no grant.
- The granted port's addr_ok=1 in the same cycle. The other port's addr_ok=0.
- SRAM drive:
  - sram_en=1 iff a grant is made.
  - sram_addr = granted address.
  - sram_wen = data_wstrb if data is granted with data_wr=1, else 4'h0.
  - sram_wdata = data_wdata, or 0 when inst is granted.
- Owner register (states NONE, INST, DATA): loaded every cycle with the grant result (NONE if no grant). Back-to-back grants are allowed with no bubbles.
- Response (cycle after grant):
  - owner==INST: inst_data_ok=1, inst_rdata=sram_rdata.
  - owner==DATA: data_data_ok=1, data_rdata=sram_rdata. data_rdata is don't-care after a write, but data_ok still pulses.
  - Non-owner port: data_ok=0, rdata=0.
- data_ok is a single-cycle pulse with no back-pressure. Requesters must accept it.
- Latency: exactly 1 cycle from addr_ok to data_ok on each port.
- Starvation counter:
  - Increments by 1 when inst_req=1 and data is granted.
  - Clears to 0 when inst is granted or inst_req=0.
  - Saturates at STARVE_MAX.
  - Width is clog2(STARVE_MAX+1), minimum 1 bit.
- Simultaneous grant and response: a new grant in the same cycle as the previous response is legal. Responses never merge or reorder.
- Reset mid-operation: an in-flight access is dropped. No data_ok is produced in the cycle after resetn returns to 1.
- Requests must hold stable until addr_ok. The arbiter neither checks nor latches unaccepted requests.

Optional Feature:
Macro SRAM_ARB_RR_EN.
- Defined: on conflict, priority alternates. A 1-bit last_grant register (reset to DATA) selects the port not granted last time. The starvation counter and STARVE_MAX are ignored, and the counter is not synthesized.
- Undefined: data priority with starvation forcing, as specified above.

Test Plan:
- Inst read only: inst_req=1, inst_addr=0xbfc00000 -> inst_addr_ok=1 and sram_en=1 with sram_addr=0xbfc00000 that cycle. Next cycle inst_data_ok=1 and inst_rdata equals the SRAM word.
- Conflict: both requesting (data read 0x1000, inst 0xbfc00004) -> data_addr_ok=1, inst_addr_ok=0. Next cycle data_data_ok=1. Inst is granted once data_req drops.
- Starvation with STARVE_MAX=3: both requesting continuously -> grants are D,D,D,I,D,D,D,I... starve_cnt reads 0,1,2,3,0.
- Write: data_wr=1, data_wstrb=4'b0011, addr 0x2000, wdata 0xdeadbeef -> sram_wen=4'b0011 and sram_wdata=0xdeadbeef. Next cycle data_data_ok=1 and inst_data_ok=0. A following inst read never sees a non-zero sram_wen.
- Back-to-back: alternating single grants I,D,I over 3 cycles -> data_ok pulses on cycles 2,3,4 to owners I,D,I with no gaps or misroutes.
- Reset mid-flight: resetn=0 in the cycle after an inst grant -> all outputs 0. After release, no inst_data_ok occurs until a new grant. With SRAM_ARB_RR_EN defined, continuous conflict yields I,D,I,D.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - arbitrates one 1-cycle-latency SRAM between inst and data ports.
// Optional round-robin conflict policy selected by SRAM_ARB_RR_EN.
module sram_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [31:0]   inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [3:0]    data_wstrb,
  input  logic [AW-1:0] data_addr,
  input  logic [31:0]   data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [31:0]   data_rdata,
  output logic          sram_en,
  output logic [3:0]    sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  owner_e owner_q, owner_d;
  logic   grant_inst, grant_data;

`ifdef SRAM_ARB_RR_EN
  // last_inst_q=1 means inst won the most recent grant; reset state favours inst first.
  logic last_inst_q, last_inst_d;

  always_comb begin
    grant_inst  = inst_req;
    grant_data  = data_req;
    last_inst_d = last_inst_q;
    if (inst_req && data_req) begin
      grant_inst = !last_inst_q;
      grant_data = last_inst_q;
    end
    if (grant_inst) begin
      last_inst_d = 1'b1;
    end else if (grant_data) begin
      last_inst_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_inst_q <= 1'b0;
    end else begin
      last_inst_q <= last_inst_d;
    end
  end
`else
  localparam int            CW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q, starve_d;
  logic          force_inst;

  assign force_inst = (STARVE_MAX != 0) && (starve_q == STARVE_LIM);

  always_comb begin
    grant_data = data_req && !(inst_req && force_inst);
    grant_inst = inst_req && (!data_req || force_inst);
    starve_d   = '0;
    if (inst_req && grant_data) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Grant drives the SRAM this cycle; owner_q routes the response one cycle later.
  always_comb begin
    owner_d      = OWN_NONE;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    sram_en      = 1'b0;
    sram_wen     = 4'h0;
    sram_addr    = '0;
    sram_wdata   = '0;
    if (grant_data) begin
      owner_d = OWN_DATA;
    end else if (grant_inst) begin
      owner_d = OWN_INST;
    end
    if (resetn) begin
      inst_addr_ok = grant_inst;
      data_addr_ok = grant_data;
      sram_en      = grant_inst | grant_data;
      if (grant_data) begin
        sram_addr  = data_addr;
        sram_wdata = data_wdata;
        sram_wen   = data_wr ? data_wstrb : 4'h0;
      end else if (grant_inst) begin
        sram_addr  = inst_addr;
      end
      if (owner_q == OWN_INST) begin
        inst_data_ok = 1'b1;
        inst_rdata   = sram_rdata;
      end else if (owner_q == OWN_DATA) begin
        data_data_ok = 1'b1;
        data_rdata   = sram_rdata;
      end
    end
  end

endmodule
